// File: rtl/adder_sweep_pkg.sv
// Shared types and constants for the adder sweep sequencer and its operand generator.
package adder_sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_RUN,
      ST_WAIT,
      ST_ACCUM,
      ST_FINISH
   } state_e;

   typedef enum logic [1:0] {
      MODE_FIXED     = 2'd0,
      MODE_WALK      = 2'd1,
      MODE_LFSR      = 2'd2,
      MODE_FIXED_ALT = 2'd3
   } mode_e;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/adder_operand_gen.sv
// Operand generator: picks the next a/b pair from the sweep mode, the completed-run
// count and the operand driven on the previous run.
module adder_operand_gen
   import adder_sweep_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int RUNS_W = 8
) (
   input  mode_e             mode_i,
   input  logic [RUNS_W-1:0] run_idx_i,
   input  logic [WIDTH-1:0]  prev_a_i,
   input  logic [WIDTH-1:0]  a_seed_i,
   input  logic [WIDTH-1:0]  b_seed_i,
   output logic [WIDTH-1:0]  a_o,
   output logic [WIDTH-1:0]  b_o
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [31:0] shamt;

   assign shamt = 32'(run_idx_i) % 32'(WIDTH);

   always_comb begin
      a_o = a_seed_i;
      b_o = b_seed_i;
      unique case (mode_i)
         MODE_WALK: begin
            // all-ones b forces the carry to ripple from the walking bit upward
            a_o = ONE << shamt;
            b_o = '1;
         end
         MODE_LFSR: begin
            if (run_idx_i != '0) begin
               a_o = (prev_a_i >> 1) ^ (prev_a_i[0] ? TAPS : '0);
            end
         end
         default: begin
            a_o = a_seed_i;
            b_o = b_seed_i;
         end
      endcase
   end

endmodule

// File: rtl/adder_sweep_sequencer.sv
// Measurement sequencer: drives operand pairs and a timed ring-enable window into the
// instrumented adder, then gathers last/min/max/sum statistics of the returned counts.
module adder_sweep_sequencer
   import adder_sweep_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int CNT_W   = 32,
   parameter int WIN_W   = 16,
   parameter int RUNS_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    cfg_go,
   input  logic                    cfg_abort,
   input  logic [1:0]              cfg_mode,
   input  logic [WIDTH-1:0]        cfg_a_seed,
   input  logic [WIDTH-1:0]        cfg_b_seed,
   input  logic [RUNS_W-1:0]       cfg_runs,
   input  logic [WIN_W-1:0]        cfg_window,
   output logic [WIDTH-1:0]        add_a,
   output logic [WIDTH-1:0]        add_b,
   output logic                    add_run,
   input  logic [CNT_W-1:0]        add_count,
   input  logic                    add_count_valid,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout_err,
   output logic [RUNS_W-1:0]       run_idx,
   output logic [CNT_W-1:0]        last_count,
   output logic [CNT_W-1:0]        min_count,
   output logic [CNT_W-1:0]        max_count,
   output logic [CNT_W+RUNS_W-1:0] sum_count
);

   localparam int             SUM_W   = CNT_W + RUNS_W;
   localparam int             TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_e                 state_q;
   logic                   busy_q, done_q, timeout_q, add_run_q;
   logic [WIDTH-1:0]       add_a_q, add_b_q;
   logic [RUNS_W-1:0]      run_idx_q;
   logic [CNT_W-1:0]       last_q, min_q, max_q;
   logic [SUM_W-1:0]       sum_q;
   logic [WIN_W-1:0]       win_q;
   logic [TO_W-1:0]        wait_q;

   // configuration snapshot and captured count: datapath only, no reset needed
   mode_e                  mode_q;
   logic [WIDTH-1:0]       a_seed_q, b_seed_q;
   logic [RUNS_W-1:0]      runs_q;
   logic [WIN_W-1:0]       window_q;
   logic [CNT_W-1:0]       cnt_q;

   logic                   go_accept;
   logic [WIDTH-1:0]       a_d, b_d;
   logic [RUNS_W-1:0]      run_idx_d;
   logic [SUM_W-1:0]       sum_d;

   assign go_accept = (state_q == ST_IDLE) && cfg_go && !cfg_abort;
   assign run_idx_d = run_idx_q + RUNS_W'(1);
   assign sum_d     = sum_q + SUM_W'(cnt_q);

   adder_operand_gen #(
      .WIDTH  (WIDTH),
      .RUNS_W (RUNS_W)
   ) u_opgen (
      .mode_i    (mode_q),
      .run_idx_i (run_idx_q),
      .prev_a_i  (add_a_q),
      .a_seed_i  (a_seed_q),
      .b_seed_i  (b_seed_q),
      .a_o       (a_d),
      .b_o       (b_d)
   );

   always_ff @(posedge wb_clk_i) begin
      if (go_accept) begin
         mode_q   <= mode_e'(cfg_mode);
         a_seed_q <= cfg_a_seed;
         b_seed_q <= cfg_b_seed;
         runs_q   <= cfg_runs;
         window_q <= cfg_window;
      end
      if (state_q == ST_WAIT && add_count_valid) begin
         cnt_q <= add_count;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         add_run_q <= 1'b0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         run_idx_q <= '0;
         last_q    <= '0;
         min_q     <= '1;
         max_q     <= '0;
         sum_q     <= '0;
         win_q     <= '0;
         wait_q    <= '0;
      end else if (cfg_abort) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         add_run_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cfg_go) begin
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  timeout_q <= 1'b0;
                  run_idx_q <= '0;
                  last_q    <= '0;
                  min_q     <= '1;
                  max_q     <= '0;
                  sum_q     <= '0;
                  state_q   <= (cfg_runs == '0) ? ST_FINISH : ST_LOAD;
               end
            end
            ST_LOAD: begin
               add_a_q <= a_d;
               add_b_q <= b_d;
               state_q <= ST_SETTLE;
            end
            ST_SETTLE: begin
               add_run_q <= 1'b1;
               win_q     <= (window_q == '0) ? WIN_W'(1) : window_q;
               state_q   <= ST_RUN;
            end
            ST_RUN: begin
               if (win_q == WIN_W'(1)) begin
                  add_run_q <= 1'b0;
                  wait_q    <= '0;
                  state_q   <= ST_WAIT;
               end else begin
                  win_q <= win_q - WIN_W'(1);
               end
            end
            ST_WAIT: begin
               if (add_count_valid) begin
                  state_q <= ST_ACCUM;
               end else if (wait_q == TO_LAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_FINISH;
               end else begin
                  wait_q <= wait_q + TO_W'(1);
               end
            end
            ST_ACCUM: begin
               last_q    <= cnt_q;
               if (cnt_q < min_q) min_q <= cnt_q;
               if (cnt_q > max_q) max_q <= cnt_q;
               sum_q     <= sum_d;
               run_idx_q <= run_idx_d;
               state_q   <= (run_idx_d == runs_q) ? ST_FINISH : ST_LOAD;
            end
            ST_FINISH: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q    <= 1'b0;
               add_run_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign add_a       = add_a_q;
   assign add_b       = add_b_q;
   assign add_run     = add_run_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = timeout_q;
   assign run_idx     = run_idx_q;
   assign last_count  = last_q;
   assign min_count   = min_q;
   assign max_count   = max_q;
   assign sum_count   = sum_q;

endmodule

// File: tb/tb_adder_sweep_sequencer.sv
// Bench for adder_sweep_sequencer: directed table, multi-cycle corner sequences and
// randomized sweeps against a behavioural adder/statistics model.
module tb_adder_sweep_sequencer;

   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_go, cfg_abort;
   logic [1:0]  cfg_mode;
   logic [31:0] cfg_a_seed, cfg_b_seed;
   logic [7:0]  cfg_runs;
   logic [15:0] cfg_window;
   logic [31:0] add_a, add_b;
   logic        add_run;
   logic [31:0] add_count;
   logic        add_count_valid;
   logic        busy, done, timeout_err;
   logic [7:0]  run_idx;
   logic [31:0] last_count, min_count, max_count;
   logic [39:0] sum_count;

   always #5 clk = ~clk;

   adder_sweep_sequencer dut (
      .wb_clk_i        (clk),
      .wb_rst_i        (rst),
      .cfg_go          (cfg_go),
      .cfg_abort       (cfg_abort),
      .cfg_mode        (cfg_mode),
      .cfg_a_seed      (cfg_a_seed),
      .cfg_b_seed      (cfg_b_seed),
      .cfg_runs        (cfg_runs),
      .cfg_window      (cfg_window),
      .add_a           (add_a),
      .add_b           (add_b),
      .add_run         (add_run),
      .add_count       (add_count),
      .add_count_valid (add_count_valid),
      .busy            (busy),
      .done            (done),
      .timeout_err     (timeout_err),
      .run_idx         (run_idx),
      .last_count      (last_count),
      .min_count       (min_count),
      .max_count       (max_count),
      .sum_count       (sum_count)
   );

   int nvec = 0;
   int nerr = 0;

   // behavioural adder side: answers each add_run window and records what it saw
   logic [31:0] resp_cnt[$];
   logic [31:0] obs_a[$], obs_b[$];
   int          obs_len[$];
   bit          resp_en = 1'b1;
   int          resp_delay = 3;
   bit          mdl_prev = 1'b0;
   int          mdl_pend = 0;
   int          mdl_len = 0;

   initial begin
      add_count = '0;
      add_count_valid = 1'b0;
      forever begin
         @(posedge clk); #1;
         add_count_valid = 1'b0;
         if (mdl_pend > 0) begin
            mdl_pend--;
            if (mdl_pend == 0) begin
               add_count_valid = 1'b1;
               add_count = (resp_cnt.size() > 0) ? resp_cnt.pop_front() : 32'h0;
            end
         end
         if (add_run && !mdl_prev) begin
            obs_a.push_back(add_a);
            obs_b.push_back(add_b);
            mdl_len = 1;
         end else if (add_run) begin
            mdl_len++;
         end else if (mdl_prev) begin
            obs_len.push_back(mdl_len);
            if (resp_en) mdl_pend = resp_delay;
         end
         mdl_prev = add_run;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic run_sweep(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] runs, input logic [15:0] win);
      int n;
      obs_a.delete(); obs_b.delete(); obs_len.delete();
      cfg_mode = m; cfg_a_seed = a; cfg_b_seed = b; cfg_runs = runs; cfg_window = win;
      cfg_go = 1'b1;
      tick();
      cfg_go = 1'b0;
      n = 0;
      while (!done && n < 5000) begin
         tick();
         n++;
      end
   endtask

   task automatic verify(input string tag, input int runs, input int win,
                         input logic [31:0] ea[$], input logic [31:0] eb[$],
                         input logic [31:0] elast, input logic [31:0] emin,
                         input logic [31:0] emax, input logic [39:0] esum);
      int elen;
      elen = (win == 0) ? 1 : win;
      check({tag, " done"}, 64'(done), 64'(1));
      check({tag, " busy"}, 64'(busy), 64'(0));
      check({tag, " timeout_err"}, 64'(timeout_err), 64'(0));
      check({tag, " run_idx"}, 64'(run_idx), 64'(runs));
      check({tag, " last"}, 64'(last_count), 64'(elast));
      check({tag, " min"}, 64'(min_count), 64'(emin));
      check({tag, " max"}, 64'(max_count), 64'(emax));
      check({tag, " sum"}, 64'(sum_count), 64'(esum));
      check({tag, " run windows"}, 64'(obs_len.size()), 64'(runs));
      for (int i = 0; i < runs; i++) begin
         check($sformatf("%s add_a[%0d]", tag, i),
               64'((i < obs_a.size()) ? obs_a[i] : 32'hDEAD_BEEF), 64'(ea[i]));
         check($sformatf("%s add_b[%0d]", tag, i),
               64'((i < obs_b.size()) ? obs_b[i] : 32'hDEAD_BEEF), 64'(eb[i]));
         check($sformatf("%s run_len[%0d]", tag, i),
               64'((i < obs_len.size()) ? obs_len[i] : -1), 64'(elen));
      end
   endtask

   function automatic logic [31:0] ref_a(input int mode, input logic [31:0] seed, input int k);
      logic [31:0] x;
      x = seed;
      if (mode == 1) begin
         x = 32'h1 << (k % 32);
      end else if (mode == 2) begin
         for (int j = 0; j < k; j++) x = (x >> 1) ^ (x[0] ? TAPS : 32'h0);
      end
      return x;
   endfunction

   typedef struct packed {
      logic [1:0]       mode;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [7:0]       runs;
      logic [15:0]      window;
      logic [3:0][31:0] cnt;
      logic [3:0][31:0] exp_a;
      logic [3:0][31:0] exp_b;
      logic [31:0]      exp_last;
      logic [31:0]      exp_min;
      logic [31:0]      exp_max;
      logic [39:0]      exp_sum;
   } vec_t;

   vec_t tbl[3];

   initial begin
      logic [31:0] ea[$], eb[$], cnts[$];
      logic [31:0] elast, emin, emax;
      logic [39:0] esum;
      int n, m, r, w;

      tbl[0] = '0;
      tbl[0].mode = 2'd0; tbl[0].a = 32'd5; tbl[0].b = 32'd3; tbl[0].runs = 8'd1; tbl[0].window = 16'd4;
      tbl[0].cnt[0] = 32'd100; tbl[0].exp_a[0] = 32'd5; tbl[0].exp_b[0] = 32'd3;
      tbl[0].exp_last = 32'd100; tbl[0].exp_min = 32'd100; tbl[0].exp_max = 32'd100; tbl[0].exp_sum = 40'd100;

      tbl[1] = '0;
      tbl[1].mode = 2'd1; tbl[1].a = 32'h1234_5678; tbl[1].b = 32'h0; tbl[1].runs = 8'd4; tbl[1].window = 16'd2;
      tbl[1].cnt[0] = 32'd10; tbl[1].cnt[1] = 32'd30; tbl[1].cnt[2] = 32'd20; tbl[1].cnt[3] = 32'd40;
      tbl[1].exp_a[0] = 32'd1; tbl[1].exp_a[1] = 32'd2; tbl[1].exp_a[2] = 32'd4; tbl[1].exp_a[3] = 32'd8;
      for (int i = 0; i < 4; i++) tbl[1].exp_b[i] = 32'hFFFF_FFFF;
      tbl[1].exp_last = 32'd40; tbl[1].exp_min = 32'd10; tbl[1].exp_max = 32'd40; tbl[1].exp_sum = 40'd100;

      tbl[2] = '0;
      tbl[2].mode = 2'd2; tbl[2].a = 32'd1; tbl[2].b = 32'd7; tbl[2].runs = 8'd2; tbl[2].window = 16'd0;
      tbl[2].cnt[0] = 32'd50; tbl[2].cnt[1] = 32'd60;
      tbl[2].exp_a[0] = 32'h0000_0001; tbl[2].exp_a[1] = 32'h8020_0003;
      tbl[2].exp_b[0] = 32'd7; tbl[2].exp_b[1] = 32'd7;
      tbl[2].exp_last = 32'd60; tbl[2].exp_min = 32'd50; tbl[2].exp_max = 32'd60; tbl[2].exp_sum = 40'd110;

      rst = 1'b1; cfg_go = 1'b0; cfg_abort = 1'b0; cfg_mode = '0;
      cfg_a_seed = '0; cfg_b_seed = '0; cfg_runs = '0; cfg_window = '0;
      repeat (3) tick();

      check("rst busy", 64'(busy), 64'(0));
      check("rst done", 64'(done), 64'(0));
      check("rst timeout_err", 64'(timeout_err), 64'(0));
      check("rst add_run", 64'(add_run), 64'(0));
      check("rst add_a", 64'(add_a), 64'(0));
      check("rst add_b", 64'(add_b), 64'(0));
      check("rst run_idx", 64'(run_idx), 64'(0));
      check("rst last", 64'(last_count), 64'(0));
      check("rst min", 64'(min_count), 64'hFFFF_FFFF);
      check("rst max", 64'(max_count), 64'(0));
      check("rst sum", 64'(sum_count), 64'(0));
      rst = 1'b0;
      tick();

      // directed table: fixed, walking-ones, LFSR
      for (int t = 0; t < 3; t++) begin
         resp_cnt.delete(); ea.delete(); eb.delete();
         resp_delay = 3;
         for (int k = 0; k < int'(tbl[t].runs); k++) begin
            resp_cnt.push_back(tbl[t].cnt[k]);
            ea.push_back(tbl[t].exp_a[k]);
            eb.push_back(tbl[t].exp_b[k]);
         end
         run_sweep(tbl[t].mode, tbl[t].a, tbl[t].b, tbl[t].runs, tbl[t].window);
         verify($sformatf("tbl%0d", t), int'(tbl[t].runs), int'(tbl[t].window), ea, eb,
                tbl[t].exp_last, tbl[t].exp_min, tbl[t].exp_max, tbl[t].exp_sum);
         repeat (3) tick();
      end

      // zero runs: straight to FINISH, done two cycles after go
      obs_len.delete();
      cfg_mode = 2'd0; cfg_runs = 8'd0; cfg_window = 16'd3; cfg_go = 1'b1;
      tick();
      cfg_go = 1'b0;
      check("runs0 done early", 64'(done), 64'(0));
      check("runs0 busy", 64'(busy), 64'(1));
      tick();
      check("runs0 done", 64'(done), 64'(1));
      check("runs0 busy end", 64'(busy), 64'(0));
      check("runs0 min", 64'(min_count), 64'hFFFF_FFFF);
      check("runs0 sum", 64'(sum_count), 64'(0));
      check("runs0 run_idx", 64'(run_idx), 64'(0));
      check("runs0 windows", 64'(obs_len.size()), 64'(0));
      repeat (2) tick();

      // no answer from the adder: timeout after 255 WAIT cycles
      resp_en = 1'b0;
      cfg_mode = 2'd0; cfg_a_seed = 32'd9; cfg_b_seed = 32'd1; cfg_runs = 8'd2; cfg_window = 16'd1;
      cfg_go = 1'b1;
      tick();
      cfg_go = 1'b0;
      n = 0;
      while (!add_run && n < 20) begin tick(); n++; end
      while (add_run && n < 40) begin tick(); n++; end
      n = 0;
      while (!timeout_err && n < 400) begin tick(); n++; end
      check("timeout wait cycles", 64'(n), 64'(255));
      check("timeout_err", 64'(timeout_err), 64'(1));
      tick();
      check("timeout done", 64'(done), 64'(1));
      check("timeout busy", 64'(busy), 64'(0));
      check("timeout run_idx", 64'(run_idx), 64'(0));
      check("timeout sum", 64'(sum_count), 64'(0));
      check("timeout min", 64'(min_count), 64'hFFFF_FFFF);
      resp_en = 1'b1;
      repeat (2) tick();

      // abort in the second RUN cycle, then a clean restart
      resp_cnt.delete(); resp_cnt.push_back(32'd100); resp_delay = 3;
      cfg_mode = 2'd0; cfg_a_seed = 32'd5; cfg_b_seed = 32'd3; cfg_runs = 8'd1; cfg_window = 16'd5;
      cfg_go = 1'b1;
      tick();
      cfg_go = 1'b0;
      n = 0;
      while (!add_run && n < 20) begin tick(); n++; end
      check("abort reached run", 64'(add_run), 64'(1));
      tick();
      cfg_abort = 1'b1;
      cfg_go = 1'b1;
      tick();
      cfg_abort = 1'b0;
      cfg_go = 1'b0;
      check("abort add_run", 64'(add_run), 64'(0));
      check("abort busy", 64'(busy), 64'(0));
      check("abort done", 64'(done), 64'(0));
      repeat (10) tick();
      check("abort stays idle", 64'(busy), 64'(0));
      check("abort run_idx", 64'(run_idx), 64'(0));
      resp_cnt.delete(); resp_cnt.push_back(32'd77);
      ea.delete(); eb.delete(); ea.push_back(32'd5); eb.push_back(32'd3);
      run_sweep(2'd0, 32'd5, 32'd3, 8'd1, 16'd4);
      verify("restart", 1, 4, ea, eb, 32'd77, 32'd77, 32'd77, 40'd77);
      repeat (3) tick();

      // randomized sweeps against the behavioural model
      for (int it = 0; it < 10; it++) begin
         logic [31:0] sa, sb;
         m  = $urandom_range(0, 3);
         r  = $urandom_range(1, 5);
         w  = $urandom_range(0, 4);
         sa = $urandom;
         sb = $urandom;
         resp_delay = $urandom_range(1, 6);
         resp_cnt.delete(); cnts.delete(); ea.delete(); eb.delete();
         emin = 32'hFFFF_FFFF; emax = 32'h0; esum = 40'h0; elast = 32'h0;
         for (int k = 0; k < r; k++) begin
            logic [31:0] c;
            c = $urandom;
            cnts.push_back(c);
            resp_cnt.push_back(c);
            ea.push_back(ref_a(m, sa, k));
            eb.push_back((m == 1) ? 32'hFFFF_FFFF : sb);
            if (c < emin) emin = c;
            if (c > emax) emax = c;
            esum = esum + 40'(c);
            elast = c;
         end
         run_sweep(2'(m), sa, sb, 8'(r), 16'(w));
         verify($sformatf("rnd%0d", it), r, w, ea, eb, elast, emin, emax, esum);
         repeat (2) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
